// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch port of pc_fetch_sequencer.
// master: the sequencer (drives request and address)
// slave : the instruction memory (returns the acknowledge)
interface pc_fetch_sequencer_if;
    logic        FetchReq;
    logic [31:0] FetchAddr;
    logic        FetchAck;

    modport master (
        output FetchReq,
        output FetchAddr,
        input  FetchAck
    );

    modport slave (
        input  FetchReq,
        input  FetchAddr,
        output FetchAck
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Owns the program counter and issues word-aligned instruction fetches over a
// request/acknowledge port. Branch, jump and jump-register redirects are
// turned into fetch targets here. A redirect that arrives while a request is
// outstanding squashes that fetch and is held until its acknowledge returns.
//
// Build option: define PC_TRAP_EN to send a misaligned jump-register target to
// EXC_VECTOR and pulse Trap for one cycle. Without it the low two bits of
// JumpRegAddr are dropped and the Trap port does not exist.
//
// state  | meaning
// IDLE   | just out of reset; first request goes out on the next edge
// REQ    | request outstanding, FetchAddr held until FetchAck
// WAIT   | stalled, no request outstanding
// HALTED | fetching stopped, redirects ignored, left only through reset
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef PC_TRAP_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [31:0]          BranchBase,
    input  logic [31:0]          BranchOffset,
    input  logic                 Jump,
    input  logic [25:0]          JumpIndex,
    input  logic                 JumpReg,
    input  logic [31:0]          JumpRegAddr,
    input  logic                 Halt,
    pc_fetch_sequencer_if.master fetchBus,
    output logic                 InstrValid,
    output logic [31:0]          PC,
    output logic [31:0]          PCPlus4,
    output logic                 Halted
`ifdef PC_TRAP_EN
    ,
    output logic                 Trap
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } seqState_t;

    seqState_t   state;
    seqState_t   stateNext;

    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic [31:0] fetchAddrNext;
    logic [31:0] seqAddr;

    logic        heldValid;
    logic        heldValidNext;
    logic [31:0] heldTarget;
    logic [31:0] heldTargetNext;
    logic        squashed;
    logic        squashedNext;
    logic        haltPending;
    logic        haltPendingNext;

    logic        instrValidNext;
    logic [31:0] pcNext;
    logic [31:0] pcPlus4Next;

    logic        redirActive;
    logic        redirNow;
    logic [31:0] jrTarget;
    logic [31:0] redirTarget;
    logic        killNow;
    logic        haltNow;

`ifdef PC_TRAP_EN
    logic        trapHit;
`endif

    assign fetchBus.FetchReq  = fetchReq;
    assign fetchBus.FetchAddr = fetchAddr;

    // Redirects are only honoured while the sequencer is actively fetching.
    assign redirActive = (state == REQ) || (state == WAIT);
    assign redirNow    = redirActive && (JumpReg || Jump || BranchTaken);
    assign seqAddr     = fetchAddr + 32'd4;

`ifdef PC_TRAP_EN
    assign trapHit = redirNow && JumpReg && (JumpRegAddr[1:0] != 2'b00);
`endif

    // Redirect target selection; JumpReg beats Jump beats BranchTaken.
    always_comb begin
        jrTarget    = JumpRegAddr & 32'hFFFF_FFFC;
        redirTarget = BranchBase + (BranchOffset << 2);
`ifdef PC_TRAP_EN
        if (JumpRegAddr[1:0] != 2'b00) begin
            jrTarget = EXC_VECTOR;
        end
`endif
        if (JumpReg) begin
            redirTarget = jrTarget;
        end else if (Jump) begin
            redirTarget = {BranchBase[31:28], JumpIndex, 2'b00};
        end
    end

    // Next-state and next-value logic for the fetch sequencer.
    always_comb begin
        stateNext       = state;
        fetchAddrNext   = fetchAddr;
        heldValidNext   = heldValid;
        heldTargetNext  = heldTarget;
        squashedNext    = squashed;
        haltPendingNext = haltPending;
        instrValidNext  = 1'b0;
        pcNext          = PC;
        pcPlus4Next     = PCPlus4;
        killNow         = 1'b0;
        haltNow         = 1'b0;

        case (state)
            IDLE: begin
                stateNext = REQ;
            end

            REQ: begin
                // Anything that changes flow while the fetch is in flight
                // makes its returning instruction stale.
                killNow = squashed || redirNow || Halt;
                haltNow = haltPending || Halt;

                if (redirNow) begin
                    heldValidNext  = 1'b1;
                    heldTargetNext = redirTarget;
                end
                if (Halt) begin
                    haltPendingNext = 1'b1;
                end
                squashedNext = killNow;

                if (fetchBus.FetchAck) begin
                    instrValidNext = !killNow;
                    if (!killNow) begin
                        pcNext      = fetchAddr;
                        pcPlus4Next = seqAddr;
                    end

                    if (redirNow) begin
                        fetchAddrNext = redirTarget;
                    end else if (heldValid) begin
                        fetchAddrNext = heldTarget;
                    end else begin
                        fetchAddrNext = seqAddr;
                    end

                    heldValidNext   = 1'b0;
                    squashedNext    = 1'b0;
                    haltPendingNext = 1'b0;

                    if (haltNow) begin
                        stateNext = HALTED;
                    end else if (Stall) begin
                        stateNext = WAIT;
                    end else begin
                        stateNext = REQ;
                    end
                end
            end

            WAIT: begin
                // Nothing is in flight, so a redirect lands directly.
                if (redirNow) begin
                    fetchAddrNext = redirTarget;
                end
                if (Halt) begin
                    stateNext = HALTED;
                end else if (!Stall) begin
                    stateNext = REQ;
                end
            end

            HALTED: begin
                stateNext = HALTED;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Address, held redirect and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fetchReq    <= 1'b0;
            fetchAddr   <= RESET_PC;
            heldValid   <= 1'b0;
            heldTarget  <= RESET_PC;
            squashed    <= 1'b0;
            haltPending <= 1'b0;
            InstrValid  <= 1'b0;
            PC          <= RESET_PC;
            PCPlus4     <= RESET_PC + 32'd4;
            Halted      <= 1'b0;
        end else begin
            fetchReq    <= (stateNext == REQ);
            fetchAddr   <= fetchAddrNext;
            heldValid   <= heldValidNext;
            heldTarget  <= heldTargetNext;
            squashed    <= squashedNext;
            haltPending <= haltPendingNext;
            InstrValid  <= instrValidNext;
            PC          <= pcNext;
            PCPlus4     <= pcPlus4Next;
            Halted      <= (stateNext == HALTED);
        end
    end

`ifdef PC_TRAP_EN
    // One-cycle trap pulse alongside the exception redirect.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Trap <= 1'b0;
        end else begin
            Trap <= trapHit;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: random episodes against a transaction-level
// reference model, followed by directed scenarios with fixed expected values.
// Build with PC_TRAP_EN defined to exercise the trap variant.
module tb_pc_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        iStall;
    logic        iBr;
    logic [31:0] iBase;
    logic [31:0] iOff;
    logic        iJmp;
    logic [25:0] iIdx;
    logic        iJr;
    logic [31:0] iJra;
    logic        iHalt;
    logic        ackWant;

    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Halted;
`ifdef PC_TRAP_EN
    logic        Trap;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // reference model
    bit          mStarted;
    bit          mReq;
    logic [31:0] mAddr;
    bit          mValid;
    logic [31:0] mPc;
    bit          mHalted;
    bit          mHeld;
    logic [31:0] mHeldTgt;
    bit          mSquash;
    bit          mHaltReq;
`ifdef PC_TRAP_EN
    bit          mTrap;
`endif

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (iStall),
        .BranchTaken  (iBr),
        .BranchBase   (iBase),
        .BranchOffset (iOff),
        .Jump         (iJmp),
        .JumpIndex    (iIdx),
        .JumpReg      (iJr),
        .JumpRegAddr  (iJra),
        .Halt         (iHalt),
        .fetchBus     (bus),
        .InstrValid   (InstrValid),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .Halted       (Halted)
`ifdef PC_TRAP_EN
        ,
        .Trap         (Trap)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] modelTarget(input logic jr, input logic jmp,
                                                input logic [31:0] jra, input logic [31:0] base,
                                                input logic [31:0] off, input logic [25:0] idx);
        logic [31:0] t;
        if (jr) begin
`ifdef PC_TRAP_EN
            if (jra[1:0] != 2'b00) return 32'h0000_0080;
`endif
            t = jra;
            t[1:0] = 2'b00;
            return t;
        end
        if (jmp) begin
            t = {base[31:28], 28'h0} + {4'h0, idx, 2'b00};
            return t;
        end
        return base + off * 32'd4;
    endfunction

    task automatic clearInputs();
        iStall  = 1'b0;
        iBr     = 1'b0;
        iBase   = 32'h0;
        iOff    = 32'h0;
        iJmp    = 1'b0;
        iIdx    = 26'h0;
        iJr     = 1'b0;
        iJra    = 32'h0;
        iHalt   = 1'b0;
        ackWant = 1'b0;
    endtask

    task automatic modelReset();
        mStarted = 1'b0;
        mReq     = 1'b0;
        mAddr    = 32'h0;
        mValid   = 1'b0;
        mPc      = 32'h0;
        mHalted  = 1'b0;
        mHeld    = 1'b0;
        mHeldTgt = 32'h0;
        mSquash  = 1'b0;
        mHaltReq = 1'b0;
`ifdef PC_TRAP_EN
        mTrap    = 1'b0;
`endif
    endtask

    task automatic checkOutputs();
        checkEq("FetchReq",   32'(bus.FetchReq), 32'(mReq));
        checkEq("FetchAddr",  bus.FetchAddr,     mAddr);
        checkEq("InstrValid", 32'(InstrValid),   32'(mValid));
        checkEq("PC",         PC,                mPc);
        checkEq("PCPlus4",    PCPlus4,           mPc + 32'd4);
        checkEq("Halted",     32'(Halted),       32'(mHalted));
`ifdef PC_TRAP_EN
        checkEq("Trap",       32'(Trap),         32'(mTrap));
`endif
    endtask

    // Apply the current inputs for one clock, advance the model, check at negedge.
    task automatic tick();
        bit          ack;
        bit          redir;
        logic [31:0] tgt;
        ack = ackWant && mReq;
        bus.FetchAck = ack;
        redir = mStarted && !mHalted && (iJr || iJmp || iBr);
        tgt = modelTarget(iJr, iJmp, iJra, iBase, iOff, iIdx);
        mValid = 1'b0;
`ifdef PC_TRAP_EN
        mTrap = redir && iJr && (iJra[1:0] != 2'b00);
`endif
        if (!mStarted) begin
            mStarted = 1'b1;
            mReq = 1'b1;
        end else if (mHalted) begin
            mReq = 1'b0;
        end else if (mReq) begin
            if (redir) begin
                mHeld = 1'b1;
                mHeldTgt = tgt;
                mSquash = 1'b1;
            end
            if (iHalt) begin
                mHaltReq = 1'b1;
                mSquash = 1'b1;
            end
            if (ack) begin
                if (!mSquash) begin
                    mValid = 1'b1;
                    mPc = mAddr;
                end
                mAddr = mHeld ? mHeldTgt : mAddr + 32'd4;
                mHeld = 1'b0;
                mSquash = 1'b0;
                if (mHaltReq) begin
                    mHalted = 1'b1;
                    mReq = 1'b0;
                end else begin
                    mReq = !iStall;
                end
            end
        end else begin
            if (redir) mAddr = tgt;
            if (iHalt) mHalted = 1'b1;
            else if (!iStall) mReq = 1'b1;
        end
        @(negedge Clk);
        checkOutputs();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic doReset();
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        clearInputs();
        bus.FetchAck = 1'b0;
        #1;
        checkEq("rst FetchReq",   32'(bus.FetchReq), 32'h0);
        checkEq("rst FetchAddr",  bus.FetchAddr,     32'h0);
        checkEq("rst InstrValid", 32'(InstrValid),   32'h0);
        checkEq("rst PC",         PC,                32'h0);
        checkEq("rst PCPlus4",    PCPlus4,           32'h4);
        checkEq("rst Halted",     32'(Halted),       32'h0);
`ifdef PC_TRAP_EN
        checkEq("rst Trap",       32'(Trap),         32'h0);
`endif
        modelReset();
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        Rst = 1'b0;
        clearInputs();
        bus.FetchAck = 1'b0;
        modelReset();

        // random episodes
        for (int ep = 0; ep < 4; ep++) begin
            doReset();
            for (int c = 0; c < 400; c++) begin
                iStall  = ($urandom_range(0, 99) < 30);
                iBr     = ($urandom_range(0, 99) < 10);
                iJmp    = ($urandom_range(0, 99) < 6);
                iJr     = ($urandom_range(0, 99) < 6);
                iBase   = $urandom;
                iOff    = $urandom;
                iIdx    = 26'($urandom);
                iJra    = $urandom;
                iHalt   = ($urandom_range(0, 999) < 3);
                ackWant = ($urandom_range(0, 99) < 60);
                tick();
            end
        end

        // sequential fetch with memory always acknowledging
        doReset();
        ackWant = 1'b1;
        tick();
        checkEq("seq first addr", bus.FetchAddr, 32'h0);
        checkEq("seq first req",  32'(bus.FetchReq), 32'h1);
        tick();
        checkEq("seq addr4",   bus.FetchAddr, 32'h4);
        checkEq("seq valid0",  32'(InstrValid), 32'h1);
        checkEq("seq pc0",     PC, 32'h0);
        tick();
        checkEq("seq addr8",   bus.FetchAddr, 32'h8);
        checkEq("seq valid1",  32'(InstrValid), 32'h1);
        checkEq("seq pc4",     PC, 32'h4);

        // backward branch with acknowledge in the same cycle
        iBase = 32'h0000_0100;
        iOff  = 32'hFFFF_FFFC;
        iBr   = 1'b1;
        tick();
        checkEq("br squash",  32'(InstrValid), 32'h0);
        checkEq("br target",  bus.FetchAddr, 32'h0000_00F0);

        // jump wins over a simultaneous branch
        iBase = 32'h4000_0010;
        iIdx  = 26'h000_0040;
        iJmp  = 1'b1;
        iBr   = 1'b1;
        tick();
        checkEq("jmp target", bus.FetchAddr, 32'h4000_0100);
        clearInputs();
        ackWant = 1'b1;
        tick();
        checkEq("jmp pc", PC, 32'h4000_0100);

        // sequential wrap at the top of the address space
        iBase = 32'hF000_0000;
        iIdx  = 26'h3FF_FFFF;
        iJmp  = 1'b1;
        tick();
        checkEq("wrap top", bus.FetchAddr, 32'hFFFF_FFFC);
        clearInputs();
        ackWant = 1'b1;
        tick();
        checkEq("wrap addr",    bus.FetchAddr, 32'h0);
        checkEq("wrap pcplus4", PCPlus4, 32'h0);

        // stall for four cycles, acknowledge arrives two cycles late
        iStall  = 1'b1;
        ackWant = 1'b0;
        tick();
        checkEq("stall req held", 32'(bus.FetchReq), 32'h1);
        tick();
        ackWant = 1'b1;
        tick();
        checkEq("stall ack valid", 32'(InstrValid), 32'h1);
        checkEq("stall ack pc",    PC, 32'h0);
        checkEq("stall req off",   32'(bus.FetchReq), 32'h0);
        tick();
        checkEq("stall still off", 32'(bus.FetchReq), 32'h0);
        iStall = 1'b0;
        tick();
        checkEq("stall resume req",  32'(bus.FetchReq), 32'h1);
        checkEq("stall resume addr", bus.FetchAddr, 32'h4);

        // misaligned jump-register target
        iJr  = 1'b1;
        iJra = 32'h0000_1002;
        tick();
`ifdef PC_TRAP_EN
        checkEq("jr trap addr",  bus.FetchAddr, 32'h0000_0080);
        checkEq("jr trap pulse", 32'(Trap), 32'h1);
`else
        checkEq("jr aligned addr", bus.FetchAddr, 32'h0000_1000);
`endif
        clearInputs();
        tick();
`ifdef PC_TRAP_EN
        checkEq("jr trap end", 32'(Trap), 32'h0);
`endif
        checkEq("prereset req", 32'(bus.FetchReq), 32'h1);

        // reset in the middle of a request, then halt an outstanding fetch
        doReset();
        tick();
        iHalt = 1'b1;
        tick();
        iHalt   = 1'b0;
        ackWant = 1'b1;
        tick();
        checkEq("halt squash", 32'(InstrValid), 32'h0);
        checkEq("halt flag",   32'(Halted), 32'h1);
        checkEq("halt req",    32'(bus.FetchReq), 32'h0);
        iJmp = 1'b1;
        iIdx = 26'h000_0123;
        tick();
        tick();
        checkEq("halted req",  32'(bus.FetchReq), 32'h0);
        checkEq("halted flag", 32'(Halted), 32'h1);
        clearInputs();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
